// File: rtl/lifo_stack.sv
// Parametrised single-clock LIFO stack with occupancy count, threshold flags and push+pop replace.
// Optional sticky overflow/underflow flags are built when LIFO_STACK_ERR_EN is defined.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AF_TH = DEPTH - 4,
  parameter int AE_TH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    top;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             replace;
  logic             inc;
  logic             dec;
  logic             rd_ok;
  logic             wr_en;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign top     = count - CW'(1);
  assign top_idx = top[AW-1:0];

  // A pop on an empty stack never blocks the accompanying push.
  assign replace = push & pop & ~empty;
  assign inc     = push & ~full & (~pop | empty);
  assign dec     = pop & ~push & ~empty;
  assign rd_ok   = pop & ~empty;
  assign wr_en   = replace | inc;
  assign wr_idx  = replace ? top_idx : count[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) begin
        dout <= mem[top_idx];
      end
      if (inc) begin
        count <= count + CW'(1);
      end else if (dec) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef LIFO_STACK_ERR_EN
  logic ov_evt;
  logic un_evt;

  assign ov_evt = push & ~pop & full;
  assign un_evt = pop & empty;

  // An error event in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err) | ov_evt;
      underflow <= (underflow & ~clr_err) | un_evt;
    end
  end
`else
  // Flags are constant zero; clr_err is folded in only so the input stays connected.
  assign overflow  = 1'b0 & clr_err;
  assign underflow = 1'b0 & clr_err;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (WIDTH=8, DEPTH=64): vector table plus multi-cycle corner sequences.
// Expected error flags follow the LIFO_STACK_ERR_EN build setting.
module tb_lifo_stack;

`ifdef LIFO_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic       clr_err;
  logic [7:0] dout;
  logic       dout_valid;
  logic [6:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  lifo_stack #(.WIDTH(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       vld;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[20];
  logic [7:0] vals[64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
    push = p; pop = q; din = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    //            push pop clr din    cnt dout   vld ov un
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h02, 2, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h03, 3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h77, 3, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h77, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h5A, 1'b0, 1'b0, 1'b0};

    push = 1'b0; pop = 1'b0; din = 8'h00; clr_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset_count", int'(count), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_almost_empty", int'(almost_empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_almost_full", int'(almost_full), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_underflow", int'(underflow), 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      check($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
      check($sformatf("v%0d_dout", i), int'(dout), int'(vecs[i].dout));
      check($sformatf("v%0d_valid", i), int'(dout_valid), int'(vecs[i].vld));
      check($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].cnt == 0));
      check($sformatf("v%0d_ae", i), int'(almost_empty), int'(vecs[i].cnt <= 4));
      check($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].ov & ERR));
      check($sformatf("v%0d_underflow", i), int'(underflow), int'(vecs[i].un & ERR));
    end

    // Fill to full, watching the upper threshold.
    for (int i = 0; i < 64; i++) begin
      vals[i] = 8'($urandom_range(0, 255));
      step(1'b1, 1'b0, vals[i], 1'b0);
      check($sformatf("fill%0d_count", i), int'(count), i + 1);
      check($sformatf("fill%0d_af", i), int'(almost_full), int'((i + 1) >= 60));
      check($sformatf("fill%0d_full", i), int'(full), int'((i + 1) == 64));
    end
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_count", int'(count), 64);
    check("ovf_full", int'(full), 1);
    check("ovf_flag", int'(overflow), int'(ERR));
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf_sticky", int'(overflow), int'(ERR));
    check("ovf_no_valid", int'(dout_valid), 0);

    for (int i = 63; i >= 0; i--) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check($sformatf("drain%0d_dout", i), int'(dout), int'(vals[i]));
      check($sformatf("drain%0d_valid", i), int'(dout_valid), 1);
      check($sformatf("drain%0d_count", i), int'(count), i);
    end
    check("drain_empty", int'(empty), 1);
    check("drain_underflow", int'(underflow), 0);

    // Error event coinciding with clr_err: set wins.
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("setwins_underflow", int'(underflow), int'(ERR));
    check("setwins_overflow_cleared", int'(overflow), 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_underflow", int'(underflow), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    check("pre_reset_count", int'(count), 5);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_reset_valid", int'(dout_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_dout", int'(dout), 0);
    check("async_reset_valid", int'(dout_valid), 0);
    check("async_reset_empty", int'(empty), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h9C, 1'b0);
    check("post_reset_count", int'(count), 1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("post_reset_dout", int'(dout), 8'h9C);
    check("post_reset_valid", int'(dout_valid), 1);
    check("post_reset_empty", int'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO stack and successor to the fixed 8x64 `lifo`. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and a same-cycle push+pop that replaces the top entry. It also provides a registered read-valid strobe and optional sticky overflow/underflow error flags. It sits between a producer/consumer pair as a single-clock buffer with last-in-first-out ordering.

## Interface
- `WIDTH`, 8, data width in bits (>=1)
- `DEPTH`, 64, number of entries (>=2)
- `AF_TH`, DEPTH-4, `almost_full` asserts when count >= AF_TH
- `AE_TH`, 4, `almost_empty` asserts when count <= AE_TH
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `push`  in  1  write request
- `pop`  in  1  read request
- `din`  in  WIDTH  push data
- `clr_err`  in  1  synchronous clear of the sticky error flags
- `dout`  out  WIDTH  registered popped data; holds its value between pops
- `dout_valid`  out  1  one-cycle pulse the cycle after an accepted pop
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- `full`, `empty`  out  1  count==DEPTH / count==0
- `almost_full`, `almost_empty`  out  1  threshold flags
- `overflow`, `underflow`  out  1  sticky error flags

## Operation
- Storage is `mem[0..DEPTH-1]`. `count` doubles as the stack pointer, so the top entry is `mem[count-1]`. Memory is not reset.
- Push only, not full: `mem[count] <= din`, then `count+1`.
- Push only, full: data is dropped, `count` is unchanged, and `overflow` is set.
- Pop only, not empty: `dout <= mem[count-1]`, then `count-1`, and `dout_valid` pulses.
- Pop only, empty: `dout` is held, there is no `dout_valid`, and `underflow` is set.
- Push+pop, not empty (including full): replace.
  - `dout <= mem[count-1]` and `mem[count-1] <= din`.
  - `count` is unchanged and `dout_valid` pulses.
  - Neither error flag is set.
- Push+pop, empty: the push executes (`mem[0] <= din`, count becomes 1). The pop is rejected, `underflow` is set, and there is no `dout_valid`.
- Status flags are combinational decodes of the registered `count` only. They have no input-to-output combinational path.
- `clr_err` clears both sticky flags. If an error event and `clr_err` occur in the same cycle, the flag ends up set (the set wins).
- Count arithmetic uses the `$clog2(DEPTH+1)` width. It never wraps: pushes saturate at DEPTH and pops at 0, with the error flags recording the rejected operation.

## Timing
- All outputs are registered or decoded from registers, so outputs update one edge after the request.
- Pop latency is 1: data and `dout_valid` appear the cycle after `pop` is sampled high.
- A push is visible in `count` and the flags one cycle after it is sampled. A pushed value can be popped starting the following cycle.
- No handshake back-pressure. The requester must consult `full`/`empty`; an illegal request is dropped and flagged, never stalled.
- Reset values:
  - `count`=0, `dout`=0, `dout_valid`=0.
  - `empty`=1, `full`=0, `almost_empty`=1.
  - `almost_full`=(AF_TH==0).
  - `overflow`=0, `underflow`=0.
- Reset asserted mid-operation: all registers take their reset values immediately (asynchronously) and stored contents are logically discarded. The first push after deassertion writes `mem[0]`.

## Configuration
- `LIFO_STACK_ERR_EN` defined: the `overflow`/`underflow` sticky registers and `clr_err` behave as described above.
- `LIFO_STACK_ERR_EN` undefined: `overflow` and `underflow` are tied to 0 and `clr_err` is ignored. Data path, count and status flags are identical in both builds.

## Test plan
- Reset then idle:
  - count=0, empty=1, almost_empty=1, full=0, dout=0, dout_valid=0.
  - Assert reset mid-stream after 5 pushes: count returns to 0 asynchronously.
- Push 0x01, 0x02, 0x03, then 3 pops:
  - dout sequence 0x03, 0x02, 0x01, each one cycle after its pop, each with a single `dout_valid` pulse.
  - Afterwards empty=1.
- Push 64 random values (DEPTH=64):
  - almost_full rises when count reaches 60; full=1 at count 64.
  - A 65th push (0xAA) leaves count=64 and sets overflow=1.
  - 64 pops return the values in reverse order.
- With count=3 and top 0x33, push+pop with din=0x77:
  - dout=0x33, count stays 3.
  - A following pop returns 0x77, and underflow/overflow stay 0.
- Pop while empty: underflow=1, dout unchanged, no `dout_valid`. Then `clr_err` makes underflow=0. Push+pop while empty with din=0x5A: count=1, underflow=1.
- Rebuild without `LIFO_STACK_ERR_EN` and repeat the overflow and underflow stimulus: overflow=underflow=0 throughout, all data results identical.
